// File: rtl/rotate_right_32_seq_if.sv
// ----------------------------------------------------------------------------
// rotate_right_32_seq_if
//
// Purpose:
//   Request/result bundle for the multi-cycle 32-bit rotate-right unit.
//   The requester (master) drives start/a/amt and observes ready/busy/done/y.
//   The rotator (slave) does the opposite.
//
// Signals:
//   start  1   request, sampled on a rising edge only while ready=1
//   a      32  operand, captured on the accept edge
//   amt    5   rotate-right amount 0..31, captured on the accept edge
//   ready  1   unit is idle and can accept start
//   busy   1   unit is rotating or presenting its result (always ~ready)
//   done   1   one-cycle pulse, y is valid
//   y      32  result register, holds until the next accept
// ----------------------------------------------------------------------------
interface rotate_right_32_seq_if;
    logic        start;
    logic [31:0] a;
    logic [4:0]  amt;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] y;

    modport master (
        output start,
        output a,
        output amt,
        input  ready,
        input  busy,
        input  done,
        input  y
    );

    modport slave (
        input  start,
        input  a,
        input  amt,
        output ready,
        output busy,
        output done,
        output y
    );
endinterface

// File: rtl/rotate_right_32_seq.sv
// ----------------------------------------------------------------------------
// rotate_right_32_seq
//
// Purpose:
//   Multi-cycle 32-bit rotate-right unit. The operand is captured on the
//   accept edge and rotated right one bit position per clock until the
//   5-bit amount is exhausted, then the result is flagged with a one-cycle
//   done pulse. Intended for area-constrained paths next to the
//   combinational shifters, where a full barrel stage is not justified.
//
// Ports:
//   clk    in   1   system clock, all state updates on the rising edge
//   rst_n  in   1   asynchronous active-low reset
//   bus    slave modport of rotate_right_32_seq_if:
//            start, a[31:0], amt[4:0]         (in)
//            ready, busy, done, y[31:0]        (out)
//
// Optional feature:
//   ROR_FAST_STEP_EN - when defined, the ROT state rotates by 4 positions
//   per clock while at least 4 positions remain, then by 1. Rotate cycles
//   become amt/4 + amt%4; results are identical to the base mode. When not
//   defined, the unit strictly rotates one position per clock and the
//   4-step path does not exist.
// ----------------------------------------------------------------------------
module rotate_right_32_seq (
    input  logic                        clk,
    input  logic                        rst_n,
    rotate_right_32_seq_if.slave        bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROT  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] data;
    logic [31:0] data_next;
    logic [4:0]  cnt;
    logic [4:0]  cnt_next;

    // Single-position rotate right: bit 0 wraps into bit 31.
    function automatic logic [31:0] ror1(input logic [31:0] v);
        return {v[0], v[31:1]};
    endfunction

`ifdef ROR_FAST_STEP_EN
    // Four-position rotate right: bits 3:0 wrap into bits 31:28.
    function automatic logic [31:0] ror4(input logic [31:0] v);
        return {v[3:0], v[31:4]};
    endfunction
`endif

    // ------------------------------------------------------------------
    // State, operand and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            data  <= 32'd0;
            cnt   <= 5'd0;
        end else begin
            state <= state_next;
            data  <= data_next;
            cnt   <= cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, datapath and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        data_next  = data;
        cnt_next   = cnt;

        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    data_next = bus.a;
                    cnt_next  = bus.amt;
                    // A zero amount has nothing to rotate; going straight
                    // to DONE also keeps the counter from ever wrapping.
                    state_next = (bus.amt != 5'd0) ? S_ROT : S_DONE;
                end
            end

            S_ROT: begin
`ifdef ROR_FAST_STEP_EN
                if (cnt >= 5'd4) begin
                    data_next = ror4(data);
                    cnt_next  = cnt - 5'd4;
                end else begin
                    data_next = ror1(data);
                    cnt_next  = cnt - 5'd1;
                end
                if (cnt_next == 5'd0) begin
                    state_next = S_DONE;
                end
`else
                data_next = ror1(data);
                cnt_next  = cnt - 5'd1;
                // Exit on the last step so cnt lands on 0, never below.
                if (cnt == 5'd1) begin
                    state_next = S_DONE;
                end
`endif
            end

            S_DONE: begin
                // start is ignored here; it is only sampled back in IDLE.
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registered state only
    // ------------------------------------------------------------------
    always_comb begin
        bus.ready = (state == S_IDLE);
        bus.busy  = (state != S_IDLE);
        bus.done  = (state == S_DONE);
        bus.y     = data;
    end

endmodule

// File: tb/tb_rotate_right_32_seq.sv
// ----------------------------------------------------------------------------
// tb_rotate_right_32_seq
//
// Directed testbench for rotate_right_32_seq. Expected results are
// hand-computed constants; expected rotate-edge counts follow the
// configured step mode (ROR_FAST_STEP_EN).
// ----------------------------------------------------------------------------
module tb_rotate_right_32_seq;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;
    int   lat;

    rotate_right_32_seq_if bus ();

    rotate_right_32_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int rot_edges(input int amount);
`ifdef ROR_FAST_STEP_EN
        return amount / 4 + amount % 4;
`else
        return amount;
`endif
    endfunction

    // Bounded wait for done; returns the number of edges waited.
    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 64) begin
            tick;
            n++;
        end
    endtask

    // Full operation: accept, scramble inputs, wait, check result and
    // handshake, then confirm y holds in IDLE.
    task automatic run_op(input string tag, input logic [31:0] op_a,
                          input logic [4:0] op_amt, input logic [31:0] y_exp);
        int n;
        bus.start = 1'b1;
        bus.a     = op_a;
        bus.amt   = op_amt;
        tick;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.amt   = 5'($urandom);
        check({tag, "_busy_after_accept"}, 32'(bus.busy), 32'd1);
        wait_done(n);
        check({tag, "_latency"}, 32'(n), 32'(rot_edges(int'(op_amt))));
        check({tag, "_y"}, bus.y, y_exp);
        check({tag, "_busy_with_done"}, 32'(bus.busy), 32'd1);
        check({tag, "_ready_with_done"}, 32'(bus.ready), 32'd0);
        tick;
        check({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
        check({tag, "_ready_after"}, 32'(bus.ready), 32'd1);
        tick;
        check({tag, "_y_hold"}, bus.y, y_exp);
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = 32'd0;
        bus.amt   = 5'd0;

        // Reset state
        #1;
        check("rst_y", bus.y, 32'd0);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        tick;
        tick;
        rst_n = 1'b1;
        tick;

        // Reset in the middle of an operation
        bus.start = 1'b1;
        bus.a     = 32'hFFFF_0000;
        bus.amt   = 5'd20;
        tick;
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        check("mid_busy_before_rst", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_y", bus.y, 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_ready", 32'(bus.ready), 32'd1);
        tick;
        rst_n = 1'b1;
        tick;
        run_op("post_rst", 32'h0000_0003, 5'd1, 32'h8000_0001);

        // amt=0 goes straight to DONE
        run_op("amt0", 32'hA5A5_A5A5, 5'd0, 32'hA5A5_A5A5);

        // Wrap-around and byte rotate
        run_op("wrap1", 32'h8000_0001, 5'd1, 32'hC000_0000);
        run_op("amt8", 32'h1234_5678, 5'd8, 32'h7812_3456);

        // Maximum amount and half-word swap
        run_op("amt31", 32'h0000_0001, 5'd31, 32'h0000_0002);
        run_op("amt16", 32'hDEAD_BEEF, 5'd16, 32'hBEEF_DEAD);

        // start pulsed while busy is ignored
        bus.start = 1'b1;
        bus.a     = 32'h0000_FFFF;
        bus.amt   = 5'd16;
        tick;
        bus.start = 1'b0;
        tick;
        tick;
        bus.start = 1'b1;
        bus.a     = 32'hFFFF_FFFF;
        bus.amt   = 5'd3;
        tick;
        bus.start = 1'b0;
        wait_done(lat);
        check("busy_ign_latency", 32'(lat + 3), 32'(rot_edges(16)));
        check("busy_ign_y", bus.y, 32'hFFFF_0000);
        tick;
        check("busy_ign_done_drop", 32'(bus.done), 32'd0);

        // start held high across DONE: back-to-back accepts
        bus.start = 1'b1;
        bus.a     = 32'h0000_0010;
        bus.amt   = 5'd4;
        tick;
        wait_done(lat);
        check("held1_latency", 32'(lat), 32'(rot_edges(4)));
        check("held1_y", bus.y, 32'h0000_0001);
        tick;
        check("held1_done_drop", 32'(bus.done), 32'd0);
        check("held1_ready", 32'(bus.ready), 32'd1);
        tick;
        check("held2_accepted", 32'(bus.busy), 32'd1);
        check("held2_loaded", bus.y, 32'h0000_0010);
        wait_done(lat);
        check("held2_latency", 32'(lat), 32'(rot_edges(4)));
        check("held2_y", bus.y, 32'h0000_0001);
        bus.start = 1'b0;
        tick;
        check("held2_done_drop", 32'(bus.done), 32'd0);
        check("held2_ready", 32'(bus.ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rotate_right_32_seq.md
Name: rotate_right_32_seq

Overview:
- Multi-cycle 32-bit rotate-right unit. It is the right-direction counterpart of the team's combinational 32-bit left rotator.
- It iteratively rotates an operand by a 5-bit amount, one position per cycle, with a start/ready/done handshake.
- It sits beside the combinational shifters in the multifunction shifter and serves area-constrained paths where a full barrel stage is not justified.

Parameters:
- None. Width is fixed at 32 and amount at 5 bits, matching the sibling rotators.

Ports:
- clk     input   1   system clock; all state updates on rising edge
- rst_n   input   1   asynchronous active-low reset
- start   input   1   request; sampled on a rising edge only while ready=1
- a       input   32  operand, captured on the accept edge
- amt     input   5   rotate-right amount 0..31, captured on the accept edge
- ready   output  1   high in IDLE; unit can accept start
- busy    output  1   high in ROT and DONE
- done    output  1   one-cycle pulse; y valid
- y       output  32  result register; holds value until the next accept

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE, data=0, cnt=0.
  - Outputs: y=0, ready=1, busy=0, done=0.
  - Release is synchronous to the next rising edge; no handshake survives reset.
- States: IDLE, ROT, DONE. Encoding is free; outputs are decoded from registered state.
  - IDLE: ready=1. On an edge with start=1:
    - data<=a, cnt<=amt.
    - state<=ROT if amt!=0, else state<=DONE.
  - ROT: each edge data<={data[0],data[31:1]} and cnt<=cnt-1. When cnt==1 on that edge, state<=DONE.
  - DONE: done=1 for exactly one cycle, then state<=IDLE.
- y is driven directly from data:
  - y changes on the accept edge (loads a) and during ROT.
  - Consumers sample y only when done=1.
  - After DONE, y holds the result until the next accept.
- Latency: with accept at edge E, done is high in the cycle after edge E+amt.
  - amt=0: done is high in the cycle after E.
  - amt=31: done follows after 31 rotate edges.
  - Back-to-back throughput is one operation per amt+2 cycles.
- Result: y = (a >> amt) | (a << (32-amt)) modulo 32 bits. amt=0 returns a unchanged.
- start while busy=1 is ignored silently; a and amt are not re-captured.
- start held high continuously: a new operation is accepted on the first edge back in IDLE.
- a and amt may change freely after the accept edge without affecting the result.
- The counter never underflows: the ROT exit is taken at cnt==1, and amt=0 never enters ROT.
- busy = ~ready at all times. done implies busy.

Optional Feature:
- Macro: ROR_FAST_STEP_EN
- Defined:
  - In ROT, when cnt>=4, rotate by 4 ({data[3:0],data[31:4]}) and cnt<=cnt-4.
  - Otherwise rotate by 1 as normal.
  - Exit to DONE when the post-update cnt would be 0.
  - Rotate cycles = amt/4 + amt%4 (amt=31 gives 10; amt=8 gives 2). Results are identical to the base mode.
- Undefined: strictly one position per cycle, as in the base behaviour. The 4-step mux is absent.

Test Plan:
- Reset mid-operation: accept a=0xFFFF0000, amt=20, then assert rst_n=0 after 5 cycles -> immediately y=0, busy=0, done=0, ready=1. Next accept a=0x00000003, amt=1 -> y=0x80000001.
- amt=0: a=0xA5A5A5A5 -> done in the cycle after accept, y=0xA5A5A5A5, no ROT cycles.
- Wrap: a=0x80000001, amt=1 -> y=0xC0000000, done after 1 rotate edge. a=0x12345678, amt=8 -> y=0x78123456, done after 8 rotate edges (2 with ROR_FAST_STEP_EN).
- Max amount: a=0x00000001, amt=31 -> y=0x00000002, done after 31 rotate edges (10 fast). Also a=0xDEADBEEF, amt=16 -> y=0xBEEFDEAD.
- Busy handling: during an amt=16 operation, pulse start with a=0xFFFFFFFF, amt=3 -> ignored, original result unaffected. Then start held high across DONE -> next op accepted the cycle after done drops; done pulses exactly one cycle each time.
